// File: rtl/fpu_types.sv
// Shared FPU types: exception flag vector, rounding mode and the per-ID flag table entry.
package fpu_types;

  // Packed as NV,DZ,OF,UF,NX from bit 4 down to bit 0.
  typedef logic [4:0] fflags_t;
  typedef logic [2:0] rm_t;

  localparam rm_t RM_RNE = 3'b000;

  typedef struct packed {
    logic    valid;
    fflags_t flags;
  } fflags_entry_t;

endpackage

// File: rtl/fp_fflags_table.sv
// Per-instruction-ID flag storage: issue clears, writebacks accumulate, retire reads with
// same-cycle writeback bypass and then frees the entry.
module fp_fflags_table
  import fpu_types::*;
#(
  parameter int MAX_IDS      = 8,
  parameter int RETIRE_PORTS = 2,
  parameter int ID_W         = $clog2(MAX_IDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [ID_W-1:0]              issue_id,
  input  logic                         fp_wb_valid,
  input  logic [ID_W-1:0]              fp_wb_id,
  input  fflags_t                      fp_wb_fflags,
  input  logic                         int_wb_valid,
  input  logic [ID_W-1:0]              int_wb_id,
  input  fflags_t                      int_wb_fflags,
  input  logic [RETIRE_PORTS-1:0]      rd_en,
  input  logic [RETIRE_PORTS*ID_W-1:0] rd_id,
  output logic [RETIRE_PORTS-1:0]      rd_valid,
  output fflags_t [RETIRE_PORTS-1:0]   rd_flags,
  output logic                         issue_clash
);

  fflags_entry_t entry_q [MAX_IDS];
  fflags_entry_t entry_d [MAX_IDS];

  // Priority per entry: issue > retire > writeback accumulation.
  always_comb begin
    for (int j = 0; j < MAX_IDS; j++) begin
      entry_d[j] = entry_q[j];
      if (fp_wb_valid && fp_wb_id == ID_W'(j)) begin
        entry_d[j].valid = 1'b1;
        entry_d[j].flags = entry_d[j].flags | fp_wb_fflags;
      end
      if (int_wb_valid && int_wb_id == ID_W'(j)) begin
        entry_d[j].valid = 1'b1;
        entry_d[j].flags = entry_d[j].flags | int_wb_fflags;
      end
      for (int i = 0; i < RETIRE_PORTS; i++) begin
        if (rd_en[i] && rd_id[i*ID_W +: ID_W] == ID_W'(j)) entry_d[j] = '0;
      end
      if (issue_valid && issue_id == ID_W'(j)) entry_d[j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < MAX_IDS; j++) entry_q[j] <= '0;
    end else begin
      for (int j = 0; j < MAX_IDS; j++) entry_q[j] <= entry_d[j];
    end
  end

  // Read ports see the stored entry plus any writeback landing on the same ID this cycle.
  always_comb begin
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      rd_valid[i] = entry_q[rd_id[i*ID_W +: ID_W]].valid;
      rd_flags[i] = entry_q[rd_id[i*ID_W +: ID_W]].valid ?
                    entry_q[rd_id[i*ID_W +: ID_W]].flags : '0;
      if (fp_wb_valid && fp_wb_id == rd_id[i*ID_W +: ID_W]) begin
        rd_valid[i] = 1'b1;
        rd_flags[i] = rd_flags[i] | fp_wb_fflags;
      end
      if (int_wb_valid && int_wb_id == rd_id[i*ID_W +: ID_W]) begin
        rd_valid[i] = 1'b1;
        rd_flags[i] = rd_flags[i] | int_wb_fflags;
      end
    end
  end

  assign issue_clash = issue_valid &&
                       ((fp_wb_valid && fp_wb_id == issue_id) ||
                        (int_wb_valid && int_wb_id == issue_id));

endmodule

// File: rtl/fp_fflags_commit.sv
// Architectural fcsr: accumulates retired FP flags, applies CSR writes to fflags/frm,
// and keeps the sticky FS-dirty and protocol-error indications.
module fp_fflags_commit
  import fpu_types::*;
#(
  parameter int MAX_IDS      = 8,
  parameter int RETIRE_PORTS = 2,
  parameter int ID_W         = $clog2(MAX_IDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [ID_W-1:0]              issue_id,
  input  logic                         fp_wb_valid,
  input  logic [ID_W-1:0]              fp_wb_id,
  input  logic [4:0]                   fp_wb_fflags,
  input  logic                         int_wb_valid,
  input  logic [ID_W-1:0]              int_wb_id,
  input  logic [4:0]                   int_wb_fflags,
  input  logic [RETIRE_PORTS-1:0]      retire_valid,
  input  logic [RETIRE_PORTS*ID_W-1:0] retire_id,
  input  logic [RETIRE_PORTS-1:0]      retire_is_fp,
  input  logic                         csr_we_fflags,
  input  logic                         csr_we_frm,
  input  logic [7:0]                   csr_wdata,
  output logic [4:0]                   fflags,
  output logic [2:0]                   dyn_rm,
  output logic                         fs_dirty,
  output logic                         protocol_err
);

  logic [RETIRE_PORTS-1:0]    contrib;
  logic [RETIRE_PORTS-1:0]    rd_valid;
  fflags_t [RETIRE_PORTS-1:0] rd_flags;
  logic                       issue_clash;
  fflags_t                    acc;
  logic                       missing_wb;
  fflags_t                    fflags_q;
  rm_t                        frm_q;
  logic                       dirty_q;
  logic                       perr_q;

  assign contrib = retire_valid & retire_is_fp;

  fp_fflags_table #(
    .MAX_IDS      (MAX_IDS),
    .RETIRE_PORTS (RETIRE_PORTS),
    .ID_W         (ID_W)
  ) u_table (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_id      (issue_id),
    .fp_wb_valid   (fp_wb_valid),
    .fp_wb_id      (fp_wb_id),
    .fp_wb_fflags  (fp_wb_fflags),
    .int_wb_valid  (int_wb_valid),
    .int_wb_id     (int_wb_id),
    .int_wb_fflags (int_wb_fflags),
    .rd_en         (contrib),
    .rd_id         (retire_id),
    .rd_valid      (rd_valid),
    .rd_flags      (rd_flags),
    .issue_clash   (issue_clash)
  );

  always_comb begin
    acc        = '0;
    missing_wb = 1'b0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      if (contrib[i]) begin
        if (rd_valid[i]) acc = acc | rd_flags[i];
        else             missing_wb = 1'b1;
      end
    end
  end

  // A CSR write is older than every retire in its group, so younger flags are ORed on top.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fflags_q <= '0;
      frm_q    <= RM_RNE;
      dirty_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (csr_we_fflags) fflags_q <= csr_wdata[4:0] | acc;
      else               fflags_q <= fflags_q | acc;
      if (csr_we_frm) frm_q <= csr_wdata[7:5];
      dirty_q <= dirty_q | (acc != '0) | csr_we_fflags | csr_we_frm;
      perr_q  <= perr_q | missing_wb | issue_clash;
    end
  end

  assign fflags       = fflags_q;
  assign dyn_rm       = frm_q;
  assign fs_dirty     = dirty_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_fp_fflags_commit.sv
// Directed table-driven bench for fp_fflags_commit: one row per clock, expected state after the edge.
module tb_fp_fflags_commit;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [2:0] issue_id;
  logic       fp_wb_valid;
  logic [2:0] fp_wb_id;
  logic [4:0] fp_wb_fflags;
  logic       int_wb_valid;
  logic [2:0] int_wb_id;
  logic [4:0] int_wb_fflags;
  logic [1:0] retire_valid;
  logic [5:0] retire_id;
  logic [1:0] retire_is_fp;
  logic       csr_we_fflags;
  logic       csr_we_frm;
  logic [7:0] csr_wdata;
  logic [4:0] fflags;
  logic [2:0] dyn_rm;
  logic       fs_dirty;
  logic       protocol_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       rst;
    logic       iv;  logic [2:0] iid;
    logic       fv;  logic [2:0] fid; logic [4:0] ff;
    logic       nv;  logic [2:0] nid; logic [4:0] nf;
    logic [1:0] rv;  logic [2:0] r0;  logic [2:0] r1; logic [1:0] rfp;
    logic       wf;  logic wr;        logic [7:0] wd;
    logic [4:0] ef;  logic [2:0] erm; logic ed; logic ep;
  } vec_t;

  vec_t tbl[$];

  fp_fflags_commit dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_id      (issue_id),
    .fp_wb_valid   (fp_wb_valid),
    .fp_wb_id      (fp_wb_id),
    .fp_wb_fflags  (fp_wb_fflags),
    .int_wb_valid  (int_wb_valid),
    .int_wb_id     (int_wb_id),
    .int_wb_fflags (int_wb_fflags),
    .retire_valid  (retire_valid),
    .retire_id     (retire_id),
    .retire_is_fp  (retire_is_fp),
    .csr_we_fflags (csr_we_fflags),
    .csr_we_frm    (csr_we_frm),
    .csr_wdata     (csr_wdata),
    .fflags        (fflags),
    .dyn_rm        (dyn_rm),
    .fs_dirty      (fs_dirty),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    rst           = v.rst;
    issue_valid   = v.iv;  issue_id  = v.iid;
    fp_wb_valid   = v.fv;  fp_wb_id  = v.fid; fp_wb_fflags  = v.ff;
    int_wb_valid  = v.nv;  int_wb_id = v.nid; int_wb_fflags = v.nf;
    retire_valid  = v.rv;  retire_id = {v.r1, v.r0}; retire_is_fp = v.rfp;
    csr_we_fflags = v.wf;  csr_we_frm = v.wr; csr_wdata = v.wd;
  endtask

  task automatic check(input string name, input logic [4:0] ef, input logic [2:0] erm,
                       input logic ed, input logic ep);
    vectors++;
    if (fflags !== ef) begin
      miscompares++;
      $display("FAIL %s fflags: got %b want %b", name, fflags, ef);
    end
    if (dyn_rm !== erm) begin
      miscompares++;
      $display("FAIL %s dyn_rm: got %b want %b", name, dyn_rm, erm);
    end
    if (fs_dirty !== ed) begin
      miscompares++;
      $display("FAIL %s fs_dirty: got %b want %b", name, fs_dirty, ed);
    end
    if (protocol_err !== ep) begin
      miscompares++;
      $display("FAIL %s protocol_err: got %b want %b", name, protocol_err, ep);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.ef, v.erm, v.ed, v.ep);
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0,
          2'b00, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 8'd0, 5'd0, 3'd0, 1'b0, 1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    drive(idle());
    //     rst  iv iid   fv fid ff        nv nid nf        rv     r0   r1   rfp    wf wr wd            ef        erm     ed ep
    tbl.push_back('{0, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 0 reset
    tbl.push_back('{0, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 1 reset
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 2 idle
    tbl.push_back('{1, 1,3'd3, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 3 issue 3
    tbl.push_back('{1, 0,3'd0, 1,3'd3,5'b00001, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 4 wb 3
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd3,3'd0,2'b01, 0,0,8'h00,        5'b00001,3'b000, 1,0}); // 5 retire 3
    tbl.push_back('{1, 1,3'd1, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00001,3'b000, 1,0}); // 6 issue 1
    tbl.push_back('{1, 1,3'd2, 1,3'd1,5'b10000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00001,3'b000, 1,0}); // 7 issue 2, wb 1
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 1,3'd2,5'b00100, 2'b11,3'd1,3'd2,2'b11, 0,0,8'h00,        5'b10101,3'b000, 1,0}); // 8 dual retire, bypass
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 1,0,8'b000_11111,  5'b11111,3'b000, 1,0}); // 9 csr fflags
    tbl.push_back('{1, 1,3'd4, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b11111,3'b000, 1,0}); // 10 issue 4
    tbl.push_back('{1, 0,3'd0, 1,3'd4,5'b00010, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b11111,3'b000, 1,0}); // 11 wb 4
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b10,3'd0,3'd4,2'b10, 1,0,8'b000_00000,  5'b00010,3'b000, 1,0}); // 12 csr + younger retire
    tbl.push_back('{1, 1,3'd6, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00010,3'b000, 1,0}); // 13 issue 6
    tbl.push_back('{1, 0,3'd0, 1,3'd6,5'b01000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00010,3'b000, 1,0}); // 14 wb 6
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd6,3'd0,2'b01, 0,1,8'b010_00000,  5'b01010,3'b010, 1,0}); // 15 frm + retire
    tbl.push_back('{1, 1,3'd5, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b01010,3'b010, 1,0}); // 16 issue 5
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd5,3'd0,2'b01, 0,0,8'h00,        5'b01010,3'b010, 1,1}); // 17 retire 5 no wb
    tbl.push_back('{1, 1,3'd7, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b01010,3'b010, 1,1}); // 18 issue 7
    tbl.push_back('{1, 0,3'd0, 1,3'd7,5'b11000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b01010,3'b010, 1,1}); // 19 wb 7
    tbl.push_back('{0, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 20 reset mid-op
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd7,3'd0,2'b01, 0,0,8'h00,        5'b00000,3'b000, 0,1}); // 21 id 7 was cleared
    tbl.push_back('{0, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,0}); // 22 reset
    tbl.push_back('{1, 1,3'd0, 1,3'd0,5'b10000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,1}); // 23 issue/wb clash
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd0,3'd0,2'b01, 0,0,8'h00,        5'b00000,3'b000, 0,1}); // 24 issue won
    tbl.push_back('{1, 1,3'd2, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,1}); // 25 issue 2
    tbl.push_back('{1, 0,3'd0, 1,3'd2,5'b00001, 1,3'd2,5'b00100, 2'b00,3'd0,3'd0,2'b00, 0,0,8'h00,        5'b00000,3'b000, 0,1}); // 26 double wb 2
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd2,3'd0,2'b01, 0,0,8'h00,        5'b00101,3'b000, 1,1}); // 27 retire 2
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b00,3'd0,3'd0,2'b00, 1,1,8'b111_10000,  5'b10000,3'b111, 1,1}); // 28 both csr writes
    tbl.push_back('{1, 0,3'd0, 0,3'd0,5'b00000, 0,3'd0,5'b00000, 2'b01,3'd1,3'd0,2'b00, 0,0,8'h00,        5'b10000,3'b111, 1,1}); // 29 non-fp retire

    for (int k = 0; k < tbl.size(); k++) step(tbl[k], $sformatf("row%0d", k));

    // Hand sequence: reset, then ID reuse with fp writeback bypassed into port 1 while
    // port 0 retires a non-FP op; a second retire of the freed entry must flag an error.
    v = idle(); v.rst = 1'b0;
    step(v, "seq_reset");
    v = idle(); v.iv = 1'b1; v.iid = 3'd4;
    step(v, "seq_issue4");
    v = idle(); v.fv = 1'b1; v.fid = 3'd4; v.ff = 5'b01000;
    v.rv = 2'b11; v.r0 = 3'd1; v.r1 = 3'd4; v.rfp = 2'b10;
    v.ef = 5'b01000; v.ed = 1'b1;
    step(v, "seq_bypass_p1");
    v = idle(); v.rv = 2'b01; v.r0 = 3'd4; v.rfp = 2'b01;
    v.ef = 5'b01000; v.ed = 1'b1; v.ep = 1'b1;
    step(v, "seq_retire_freed");
    v = idle(); v.ef = 5'b01000; v.ed = 1'b1; v.ep = 1'b1;
    step(v, "seq_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_fflags_commit.md
Name: fp_fflags_commit

Overview:
- Downstream of the FPU top. Captures per-instruction exception flags (fflags) at FP and integer writeback, and stores them indexed by instruction ID.
- When instructions retire in order, it ORs their flags into the architectural fcsr.fflags.
- Holds fcsr.frm and drives it back to the FPU as dyn_rm.
- Serves CSR reads and writes of fflags/frm, and reports FS-dirty for mstatus.

Parameters:
- MAX_IDS, 8, number of in-flight instruction IDs (power of two); ID_W = $clog2(MAX_IDS).
- RETIRE_PORTS, 2, instructions that can retire per cycle; port 0 is oldest.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-low (0 = reset)
- issue_valid  in  1  FP instruction issued; its table entry is cleared
- issue_id  in  ID_W  ID of the issuing instruction
- fp_wb_valid  in  1  FP-destination result accepted (done & ack)
- fp_wb_id  in  ID_W  ID of that result
- fp_wb_fflags  in  5  NV,DZ,OF,UF,NX for that result
- int_wb_valid  in  1  integer-destination FP result accepted
- int_wb_id  in  ID_W  ID of that result
- int_wb_fflags  in  5  flags for that result
- retire_valid  in  RETIRE_PORTS  per-port retire strobe
- retire_id  in  RETIRE_PORTS*ID_W  per-port retiring ID
- retire_is_fp  in  RETIRE_PORTS  retiring instruction is an FPU op
- csr_we_fflags  in  1  commit-time write of fflags
- csr_we_frm  in  1  commit-time write of frm
- csr_wdata  in  8  {frm[2:0], fflags[4:0]}
- fflags  out  5  architectural fcsr.fflags
- dyn_rm  out  3  architectural fcsr.frm
- fs_dirty  out  1  sticky; set on any flag accumulation or CSR write
- protocol_err  out  1  sticky; set when an FP retire hits an entry that was never written back

Behaviour:
- Reset (rst=0 at a clk edge):
  - fflags=0, dyn_rm=3'b000 (RNE).
  - All table valid bits=0, all stored flags=0.
  - fs_dirty=0, protocol_err=0.
  - Any in-flight contents are discarded.
- Table: MAX_IDS entries, each {valid, flags[4:0]}.
  - issue_valid: entry[issue_id] <= {0, 5'b0} next cycle.
  - fp_wb_valid: entry[fp_wb_id] <= {1, flags | fp_wb_fflags}.
  - int_wb_valid: same, on entry[int_wb_id].
  - Both writebacks to the same ID in one cycle: valid=1, flags = existing | fp | int.
  - issue and writeback to the same ID in one cycle: issue wins; protocol_err is set.
- Retire accumulation:
  - A port contributes only when retire_valid[i] & retire_is_fp[i].
  - acc = OR of entry[retire_id[i]].flags over contributing ports.
  - fflags <= fflags | acc on the next edge (1-cycle latency; the entry is read combinationally in the retire cycle).
  - A writeback to the same ID in the same cycle is bypassed into acc.
  - Contributing port whose entry has valid=0 and no same-cycle writeback: contributes 0 and sets protocol_err.
  - Retired entries get valid <= 0.
- CSR write:
  - The CSR instruction is taken as the oldest in its retire group, so retire ports in the same cycle are younger.
  - csr_we_fflags: fflags <= csr_wdata[4:0] | acc.
  - csr_we_frm: dyn_rm <= csr_wdata[7:5].
  - The two write enables are independent; both may assert together.
  - dyn_rm changes only through CSR writes and is visible the cycle after the write.
- fs_dirty <= 1 whenever (acc != 0) or any CSR write enable is asserted. Cleared only by reset.
- Reads are combinational from the registered fflags and dyn_rm; there are no read ports.
- IDs wrap modulo MAX_IDS. Reuse of an ID is safe because issue clears the entry.

Decomposition:
- fpu_types package holds:
  - fflags_t (5-bit packed NV,DZ,OF,UF,NX)
  - rm_t
  - the RNE reset constant
  - an fflags_entry_t {valid, fflags_t}
- One sub-module, fp_fflags_table: entry storage with its issue/writeback write ports and RETIRE_PORTS read ports with bypass.
- Accumulation, CSR logic and the sticky bits stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> fflags=0, dyn_rm=0, fs_dirty=0, protocol_err=0.
- Single op: issue id3, fp_wb id3 flags 5'b00001, retire port0 id3 -> fflags=5'b00001 the next cycle, fs_dirty=1.
- Dual retire with same-cycle bypass:
  - Setup: id1 holds 5'b10000; id2 receives int_wb 5'b00100 in the same cycle that ports 0/1 retire id1 and id2.
  - Expect: fflags=5'b10100 the next cycle.
- CSR write with younger retire:
  - Setup: fflags=5'b11111; csr_we_fflags with wdata fflags 0; port1 retires an op with flags 5'b00010.
  - Expect: fflags=5'b00010.
- frm path: csr_we_frm with wdata[7:5]=3'b010 -> dyn_rm=3'b010 the next cycle; a retire in the same cycle leaves dyn_rm unaffected.
- Protocol error and reset mid-operation:
  - Retire an FP op on id5 with no writeback -> protocol_err=1 and fflags unchanged.
  - Then assert rst=0 with table entries valid -> all state returns to reset values.
